// File: rtl/bus_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Slave response codes, arbiter phase encoding, and the master-select width rule.
package bus_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY  = 2'b00,
        RESP_ERROR = 2'b01,
        RESP_RETRY = 2'b10,
        RESP_SPLIT = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    // Width of the data-phase watchdog counter.
    localparam int WD_W = 8;

    // Width of a master index; at least one bit even for two masters.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Scans the requesters starting just after 'last' (wrapping modulo NUM_M) and
// returns the first one found as a one-hot vector and as an index.
module rr_pick
    import bus_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int MW    = sel_width(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [MW-1:0]    last,
    output logic [NUM_M-1:0] onehot,
    output logic [MW-1:0]    idx,
    output logic             any
);

    // cand[k] is the master examined at search position k (k=0 is last+1).
    logic [MW-1:0] cand [NUM_M];

    for (genvar gi = 0; gi < NUM_M; gi++) begin : g_cand
        assign cand[gi] = MW'((32'(last) + 32'(gi) + 32'd1) % 32'(NUM_M));
    end

    // Priority scan: walking from the far end lets the earliest position win.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NUM_M - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                any = 1'b1;
                idx = cand[k];
            end
        end
        onehot = any ? (NUM_M'(1) << idx) : '0;
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter/sequencer for a shared address/data bus.
// One master owns the bus per transfer: IDLE -> ADDR (1 cycle) -> DATA until
// ready. SPLIT parks the owner until the slave resumes it, RETRY rewinds the
// round-robin pointer so the owner wins again, ERROR pulses 'error'.
// Optional macro ARB_TIMEOUT_EN adds a DATA-phase watchdog that aborts the
// transfer after TIMEOUT cycles without ready and pulses 'timeout'.
module bus_arbiter_rr
    import bus_pkg::*;
#(
    parameter  int NUM_M   = 2,
    parameter  int TIMEOUT = 16,
    localparam int MW      = sel_width(NUM_M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NUM_M-1:0] busreq,
    input  logic             ready,
    input  logic [1:0]       response,
    input  logic [NUM_M-1:0] split_resume,
    output logic [NUM_M-1:0] grant,
    output logic [MW-1:0]    master_sel,
    output logic             bus_busy,
    output logic             error,
    output logic             timeout,
    output logic [NUM_M-1:0] split_mask
);

    if (NUM_M < 2 || NUM_M > 8 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_param_check
        $error("bus_arbiter_rr: NUM_M must be 2..8 and TIMEOUT 2..255");
    end

    arb_state_t       state_reg;
    logic [NUM_M-1:0] grant_reg;
    logic [MW-1:0]    sel_reg;
    logic             busy_reg;
    logic             error_reg;
    logic [MW-1:0]    last_reg;
    logic [NUM_M-1:0] mask_reg;
    logic [NUM_M-1:0] mask_next;
    logic [NUM_M-1:0] split_set;
    logic [NUM_M-1:0] eligible;
    logic [NUM_M-1:0] pick_onehot;
    logic [MW-1:0]    pick_idx;
    logic             pick_any;
    logic [MW-1:0]    retry_last;
    logic             wd_expire;

    // Parked (split) masters are invisible to the picker.
    assign eligible = busreq & ~mask_reg;

    rr_pick #(
        .NUM_M (NUM_M),
        .MW    (MW)
    ) u_pick (
        .req    (eligible),
        .last   (last_reg),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Pointer one behind the owner, so the next search starts at the owner.
    assign retry_last = (sel_reg == '0) ? MW'(NUM_M - 1) : sel_reg - 1'b1;

    // A SPLIT completion parks the owner; it is OR-ed in after resumes so set wins.
    assign split_set = (state_reg == ST_DATA && ready && resp_t'(response) == RESP_SPLIT)
                     ? (NUM_M'(1) << sel_reg) : '0;
    assign mask_next = (mask_reg & ~split_resume) | split_set;

`ifdef ARB_TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt_reg;
    logic            timeout_reg;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    // A stalled DATA phase expires on its TIMEOUT-th cycle; ready that cycle still wins.
    assign wd_expire = (state_reg == ST_DATA) && !ready && (wd_cnt_reg == WD_LAST);

    // Watchdog: cleared while in ADDR, counts DATA cycles without ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            timeout_reg <= wd_expire;
            if (state_reg == ST_ADDR) begin
                wd_cnt_reg <= '0;
            end else if (state_reg == ST_DATA && !ready) begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign wd_expire = 1'b0;
    assign timeout   = 1'b0;
`endif

    // Transfer sequencer with registered grant, select, busy and error outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            sel_reg   <= '0;
            busy_reg  <= 1'b0;
            error_reg <= 1'b0;
            last_reg  <= MW'(NUM_M - 1);
        end else begin
            error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pick_any) begin
                        state_reg <= ST_ADDR;
                        grant_reg <= pick_onehot;
                        sel_reg   <= pick_idx;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_ADDR: begin
                    state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (ready) begin
                        state_reg <= ST_IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                        case (resp_t'(response))
                            RESP_OKAY:  last_reg <= sel_reg;
                            RESP_ERROR: begin
                                error_reg <= 1'b1;
                                last_reg  <= sel_reg;
                            end
                            RESP_RETRY: last_reg <= retry_last;
                            RESP_SPLIT: last_reg <= sel_reg;
                            default:    last_reg <= sel_reg;
                        endcase
                    end else if (wd_expire) begin
                        state_reg <= ST_IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
                        error_reg <= 1'b1;
                        last_reg  <= sel_reg;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Split-parking mask: resumes clear bits in any state, a SPLIT sets the owner's bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask_reg <= '0;
        end else begin
            mask_reg <= mask_next;
        end
    end

    assign grant      = grant_reg;
    assign master_sel = sel_reg;
    assign bus_busy   = busy_reg;
    assign error      = error_reg;
    assign split_mask = mask_reg;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr.
// A two-master instance runs a table of directed vectors plus a watchdog
// sequence; a three-master instance runs random traffic against a
// transaction-level reference model.
module tb_bus_arbiter_rr;

    localparam int TO2 = 4;
    localparam int N3  = 3;
    localparam int TO3 = 5;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Two-master instance
    logic       rst2;
    logic [1:0] req2;
    logic       rdy2;
    logic [1:0] resp2;
    logic [1:0] res2;
    logic [1:0] grant2;
    logic       sel2;
    logic       busy2, err2, to2;
    logic [1:0] mask2;

    bus_arbiter_rr #(.NUM_M(2), .TIMEOUT(TO2)) u_dut2 (
        .clk          (clk),
        .rst          (rst2),
        .busreq       (req2),
        .ready        (rdy2),
        .response     (resp2),
        .split_resume (res2),
        .grant        (grant2),
        .master_sel   (sel2),
        .bus_busy     (busy2),
        .error        (err2),
        .timeout      (to2),
        .split_mask   (mask2)
    );

    // Three-master instance
    logic       rst3;
    logic [2:0] req3;
    logic       rdy3;
    logic [1:0] resp3;
    logic [2:0] res3;
    logic [2:0] grant3;
    logic [1:0] sel3;
    logic       busy3, err3, to3;
    logic [2:0] mask3;

    bus_arbiter_rr #(.NUM_M(N3), .TIMEOUT(TO3)) u_dut3 (
        .clk          (clk),
        .rst          (rst3),
        .busreq       (req3),
        .ready        (rdy3),
        .response     (resp3),
        .split_resume (res3),
        .grant        (grant3),
        .master_sel   (sel3),
        .bus_busy     (busy3),
        .error        (err3),
        .timeout      (to3),
        .split_mask   (mask3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Directed vector: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic       r;
        logic [1:0] req;
        logic       rdy;
        logic [1:0] resp;
        logic [1:0] res;
        logic [1:0] g;
        logic       s;
        logic       b;
        logic       e;
        logic [1:0] m;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [1:0] req, input logic rdy,
                       input logic [1:0] resp, input logic [1:0] res,
                       input logic [1:0] g, input logic s, input logic b,
                       input logic e, input logic [1:0] m);
        vec_t v;
        v = '{r, req, rdy, resp, res, g, s, b, e, m};
        vecs.push_back(v);
    endtask

    function automatic logic [15:0] pack2();
        return {9'd0, to2, err2, busy2, mask2, sel2, grant2};
    endfunction

    function automatic logic [15:0] exp2(input logic [1:0] g, input logic s, input logic b,
                                         input logic e, input logic t, input logic [1:0] m);
        return {9'd0, t, e, b, m, s, g};
    endfunction

    task automatic step2();
        @(posedge clk);
        #1;
    endtask

    // Reference model for the three-master instance (transfer-level view)
    int     m_phase;   // 0 idle, 1 address, 2 data
    int     m_owner;
    int     m_last;
    int     m_wd;
    bit [2:0] m_mask;
    bit     m_err;
    bit     m_to;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_last = N3 - 1; m_wd = 0;
        m_mask = '0; m_err = 1'b0; m_to = 1'b0;
    endtask

    task automatic model_step();
        bit [2:0] nm;
        int       c;
        bit       found;
        if (!rst3) begin
            model_reset();
            return;
        end
        nm    = m_mask & ~res3;
        m_err = 1'b0;
        m_to  = 1'b0;
        if (m_phase == 0) begin
            found = 1'b0;
            for (int k = 1; k <= N3; k++) begin
                c = (m_last + k) % N3;
                if (!found && req3[c] && !m_mask[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_wd    = 0;
        end else begin
            if (rdy3) begin
                m_phase = 0;
                case (resp3)
                    2'b00: m_last = m_owner;
                    2'b01: begin m_err = 1'b1; m_last = m_owner; end
                    2'b10: m_last = (m_owner + N3 - 1) % N3;
                    default: begin nm[m_owner] = 1'b1; m_last = m_owner; end
                endcase
            end else if (TO_EN && m_wd == TO3 - 1) begin
                m_phase = 0;
                m_err   = 1'b1;
                m_to    = 1'b1;
                m_last  = m_owner;
            end else begin
                m_wd++;
            end
        end
        m_mask = nm;
    endtask

    function automatic logic [15:0] model_out();
        logic [2:0] g;
        g = (m_phase != 0) ? 3'(1 << m_owner) : 3'b000;
        return {5'd0, m_to, m_err, (m_phase != 0), m_mask, 2'(m_owner), g};
    endfunction

    initial begin
        rst2 = 1'b0; req2 = '0; rdy2 = 1'b0; resp2 = '0; res2 = '0;
        rst3 = 1'b0; req3 = '0; rdy3 = 1'b0; resp3 = '0; res3 = '0;

        // r req rdy resp res | grant sel busy err mask
        add(0, 2'b00, 0, 2'd0, 2'b00,  2'b00, 0, 0, 0, 2'b00); // reset
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // M0 addr
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // M0 data
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b00, 0, 0, 0, 2'b00); // done
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00); // M1 addr
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00);
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b00, 1, 0, 0, 2'b00);
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // M0 again
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00);
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b00, 0, 0, 0, 2'b00);
        add(1, 2'b01, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // M0 owner
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00);
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // wait state
        add(1, 2'b11, 1, 2'd3, 2'b00,  2'b00, 0, 0, 0, 2'b01); // SPLIT M0
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b01); // M1 while M0 parked
        add(1, 2'b11, 0, 2'd0, 2'b01,  2'b10, 1, 1, 0, 2'b00); // resume M0
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b00, 1, 0, 0, 2'b00);
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // M0 back
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // ready ignored in addr
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b00, 0, 0, 0, 2'b00);
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00); // M1 owner
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00);
        add(1, 2'b11, 1, 2'd2, 2'b00,  2'b00, 1, 0, 0, 2'b00); // RETRY
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00); // M1 re-granted
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00);
        add(1, 2'b11, 1, 2'd1, 2'b00,  2'b00, 1, 0, 1, 2'b00); // ERROR pulse
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // pulse gone, M0 next
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00);
        add(1, 2'b11, 1, 2'd0, 2'b00,  2'b00, 0, 0, 0, 2'b00);
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00);
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b10, 1, 1, 0, 2'b00);
        add(1, 2'b11, 1, 2'd3, 2'b10,  2'b00, 1, 0, 0, 2'b10); // SPLIT beats resume
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b10);
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b10); // M0 in data
        add(0, 2'b11, 1, 2'd1, 2'b00,  2'b00, 0, 0, 0, 2'b00); // reset mid-transfer
        add(1, 2'b11, 0, 2'd0, 2'b00,  2'b01, 0, 1, 0, 2'b00); // M0 addr

        for (int i = 0; i < vecs.size(); i++) begin
            rst2  = vecs[i].r;
            req2  = vecs[i].req;
            rdy2  = vecs[i].rdy;
            resp2 = vecs[i].resp;
            res2  = vecs[i].res;
            step2();
            check($sformatf("vec[%0d]", i), pack2(),
                  exp2(vecs[i].g, vecs[i].s, vecs[i].b, vecs[i].e, 1'b0, vecs[i].m));
        end

        // Stalled data phase: M0 holds the bus with ready low.
        rdy2 = 1'b0; resp2 = 2'd0; res2 = 2'b00; req2 = 2'b11;
`ifdef ARB_TIMEOUT_EN
        for (int c = 1; c <= TO2; c++) begin
            step2();
            check($sformatf("wd_hold[%0d]", c), pack2(), exp2(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        end
        step2();
        check("wd_abort", pack2(), exp2(2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00));
        step2();
        check("wd_after", pack2(), exp2(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
`else
        for (int c = 1; c <= 55; c++) begin
            step2();
            check($sformatf("hold[%0d]", c), pack2(), exp2(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        end
        rdy2 = 1'b1;
        step2();
        check("hold_release", pack2(), exp2(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
`endif
        rdy2 = 1'b0; req2 = 2'b00;

        // Random traffic on the three-master instance.
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst3  = ($urandom_range(0, 199) != 0);
            req3  = 3'($urandom);
            rdy3  = ($urandom_range(0, 2) == 0);
            resp3 = 2'($urandom);
            res3  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                     ($urandom_range(0, 7) == 0)};
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("rand[%0d]", cyc),
                  {5'd0, to3, err3, busy3, mask3, sel3, grant3}, model_out());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
